// File: rtl/ycpu_pkg.sv
// Shared definitions for the CPU execute-stage blocks: FSM state encoding,
// the default divider width and a constant-evaluable log2 helper.
package ycpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH = 32;

   // Ceiling log2; usable in localparam expressions. Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/ysub_step.sv
// Combinational N-bit subtractor built as a ripple of full adders computing
// a + ~b + 1; o_carry = 1 means a >= b (no borrow).
module ysub_step
   import ycpu_pkg::*;
#(
   parameter int N = DIV_WIDTH + 1
)
(
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_carry
);

   always_comb begin
      logic w_c;
      // NOTE: blocking '=' here so w_c ripples bit to bit within one evaluation;
      // every output gets a default first so no latch is inferred.
      w_c    = 1'b1;
      o_diff = '0;
      for (int i = 0; i < N; i++) begin
         o_diff[i] = i_a[i] ^ ~i_b[i] ^ w_c;
         w_c       = (i_a[i] & ~i_b[i]) | (w_c & (i_a[i] ^ ~i_b[i]));
      end
      o_carry = w_c;
   end

endmodule

// File: rtl/yserial_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, operands
// in over a ready/valid handshake, result held until the consumer takes it.
module yserial_divider
   import ycpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int         CNT_W    = clog2(WIDTH);
   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_RUN    = ST_RUN;
   localparam logic [1:0] S_DONE   = ST_DONE;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;

   // The trial value carries one extra bit so a divisor with its MSB set
   // never overflows the comparison.
   logic [WIDTH:0]   w_t;
   logic [WIDTH:0]   w_diff;
   logic             w_carry;
   logic             w_nonneg;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_r_next;

   assign w_t = {r_r, r_q[WIDTH-1]};

   ysub_step #(.N(WIDTH + 1)) u_sub (
      .i_a     (w_t),
      .i_b     ({1'b0, r_d}),
      .o_diff  (w_diff),
      .o_carry (w_carry)
   );

   // A non-negative difference is always below the divisor, so its top bit is 0.
   assign w_nonneg = w_carry & ~w_diff[WIDTH];
   assign w_q_next = {r_q[WIDTH-2:0], w_nonneg};
   assign w_r_next = w_nonneg ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking '<=' for all state so every register sees the
      // pre-edge values, regardless of statement order.
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_d     <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_q   <= i_dividend;
                  r_d   <= i_divisor;
                  r_r   <= '0;
                  r_cnt <= '0;
                  if (i_divisor == '0) begin
                     r_quot  <= '1;
                     r_rem   <= i_dividend;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_q   <= w_q_next;
               r_r   <= w_r_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) begin
                  r_quot  <= w_q_next;
                  r_rem   <= w_r_next;
                  r_dbz   <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_in_ready    = (r_state == S_IDLE);
   assign o_out_valid   = (r_state == S_DONE);
   assign o_quotient    = r_quot;
   assign o_remainder   = r_rem;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_yserial_divider.sv
// Directed vector table, backpressure/reset sequences and a random stream
// checked against the division identity.
module tb_yserial_divider;
   import ycpu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   yserial_divider #(.WIDTH(W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   vec_t vecs[11];
   op_t  pend[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait for out_valid; lat counts edges from the
   // accept edge (inclusive) to the first cycle with out_valid high.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      q = quotient;
      r = remainder;
      z = div_by_zero;
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, " in_ready after consume"}, 64'(in_ready), 64'd1);
      check({name, " out_valid after consume"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [W-1:0] q, r;
      logic         z;
      int           lat;
      int           n_sent, n_got, cyc;
      logic         acc, cons;
      op_t          op;
      logic [63:0]  recon;

      vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
      vecs[1]  = '{a: 32'h12345678,   b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'h12345678,   z: 1'b1};
      vecs[2]  = '{a: 32'hFFFFFFFF,   b: 32'h80000001,   q: 32'd1,          r: 32'h7FFFFFFE,   z: 1'b0};
      vecs[3]  = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b0};
      vecs[4]  = '{a: 32'd9,          b: 32'd4,          q: 32'd2,          r: 32'd1,          z: 1'b0};
      vecs[5]  = '{a: 32'd5,          b: 32'd10,         q: 32'd0,          r: 32'd5,          z: 1'b0};
      vecs[6]  = '{a: 32'd0,          b: 32'd3,          q: 32'd0,          r: 32'd0,          z: 1'b0};
      vecs[7]  = '{a: 32'h80000000,   b: 32'h80000000,   q: 32'd1,          r: 32'd0,          z: 1'b0};
      vecs[8]  = '{a: 32'd1000000,    b: 32'd1000,       q: 32'd1000,       r: 32'd0,          z: 1'b0};
      vecs[9]  = '{a: 32'hDEADBEEF,   b: 32'h10,         q: 32'h0DEADBEE,   r: 32'hF,          z: 1'b0};
      vecs[10] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,          z: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset quotient", 64'(quotient), 64'd0);
      check("reset remainder", 64'(remainder), 64'd0);
      check("reset div_by_zero", 64'(div_by_zero), 64'd0);

      for (int i = 0; i < $size(vecs); i++) begin
         run_op(vecs[i].a, vecs[i].b, q, r, z, lat);
         check($sformatf("vec%0d quotient", i), 64'(q), 64'(vecs[i].q));
         check($sformatf("vec%0d remainder", i), 64'(r), 64'(vecs[i].r));
         check($sformatf("vec%0d div_by_zero", i), 64'(z), 64'(vecs[i].z));
         check($sformatf("vec%0d latency", i), 64'(lat), vecs[i].z ? 64'd1 : 64'(W + 1));
         check($sformatf("vec%0d in_ready in DONE", i), 64'(in_ready), 64'd0);
         consume($sformatf("vec%0d", i));
      end

      // Backpressure: result must hold and new requests must be ignored.
      run_op(32'd1000, 32'd33, q, r, z, lat);
      check("bp quotient", 64'(q), 64'd30);
      check("bp remainder", 64'(r), 64'd10);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = 32'd5 + 32'(i);
         divisor  = (i % 2 == 0) ? 32'd0 : 32'd1;
         tick();
         check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
         check($sformatf("bp%0d quotient", i), 64'(quotient), 64'd30);
         check($sformatf("bp%0d remainder", i), 64'(remainder), 64'd10);
         check($sformatf("bp%0d div_by_zero", i), 64'(div_by_zero), 64'd0);
      end
      in_valid = 1'b0;
      consume("bp");

      // Reset in the middle of 50 / 3, then a fresh 9 / 4.
      dividend = 32'd50;
      divisor  = 32'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("mid-run in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst in_ready", 64'(in_ready), 64'd1);
      check("midrst out_valid", 64'(out_valid), 64'd0);
      check("midrst quotient", 64'(quotient), 64'd0);
      check("midrst remainder", 64'(remainder), 64'd0);
      check("midrst div_by_zero", 64'(div_by_zero), 64'd0);
      run_op(32'd9, 32'd4, q, r, z, lat);
      check("post-rst quotient", 64'(q), 64'd2);
      check("post-rst remainder", 64'(r), 64'd1);
      check("post-rst latency", 64'(lat), 64'(W + 1));
      consume("post-rst");

      // Random back-to-back stream with random consumer backpressure.
      n_sent = 0;
      n_got  = 0;
      cyc    = 0;
      while (n_got < 1000 && cyc < 80000) begin
         in_valid = (n_sent < 1000) && ($urandom_range(0, 3) != 0);
         dividend = $urandom;
         case ($urandom_range(0, 9))
            0:       divisor = '0;
            1, 2, 3: divisor = W'($urandom_range(1, 255));
            default: divisor = $urandom;
         endcase
         out_ready = ($urandom_range(0, 1) == 1);
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cons) begin
            if (pend.size() == 0) begin
               check("stream unexpected result", 64'd1, 64'd0);
            end else begin
               op = pend.pop_front();
               if (op.b == '0) begin
                  check("stream dbz flag", 64'(div_by_zero), 64'd1);
                  check("stream dbz quotient", 64'(quotient), 64'hFFFFFFFF);
                  check("stream dbz remainder", 64'(remainder), 64'(op.a));
               end else begin
                  recon = 64'(quotient) * 64'(op.b) + 64'(remainder);
                  check("stream q*d+r", recon, 64'(op.a));
                  check("stream r<d", 64'(remainder < op.b), 64'd1);
                  check("stream dbz clear", 64'(div_by_zero), 64'd0);
               end
            end
            n_got++;
         end
         if (acc) begin
            pend.push_back('{a: dividend, b: divisor});
            n_sent++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream results received", 64'(n_got), 64'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/yserial_divider.md
# yserial_divider

Multi-cycle unsigned integer divider for the pipelined CPU's execute stage. It computes quotient and remainder one bit per cycle by restoring division, and each step is a trial subtraction. The ripple adder chain is used in the reverse direction (a + ~b + 1) rather than for addition. The ALU issues it operands over a ready/valid handshake and stalls until the result is accepted.

## Interface
- WIDTH, 32: operand, quotient and remainder width; legal range 4..64.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  divider idle and able to accept operands.
- dividend  input  WIDTH  unsigned dividend, sampled on accept.
- divisor  input  WIDTH  unsigned divisor, sampled on accept.
- out_valid  output  1  result available; held until consumed.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with the result when the accepted divisor was 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: bit steps in progress.
  - DONE: out_valid=1.
- Accept: `in_valid && in_ready` on a clock edge.
  - Captures dividend into the Q register and divisor into the D register.
  - Clears the partial-remainder register R (WIDTH+1 bits), sets the step counter to 0 and goes to RUN.
- Divisor zero at accept: goes IDLE→DONE directly.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN step, one per cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - S = T − {0, D}, computed by a WIDTH+1-bit subtract step.
  - If S is non-negative (carry-out=1): R←S, Q←{Q[WIDTH-2:0],1}.
  - Otherwise: R←T, Q←{Q[WIDTH-2:0],0}.
  - The counter increments each step.
- After step WIDTH−1 (counter == WIDTH−1): go to DONE. Quotient = Q, remainder = R[WIDTH-1:0], div_by_zero=0.
- DONE: out_valid=1; outputs are stable.
  - If out_ready=1: return to IDLE on that edge.
  - If out_ready=0: remain in DONE indefinitely.
- Operands are accepted only in IDLE. in_valid asserted in RUN or DONE is ignored, and the operand inputs are don't-care then.
- Accept and result consumption never occur on the same edge. After consumption there is at least one IDLE cycle.
- Arithmetic:
  - Unsigned only; the signed fixup is done by the ALU wrapper.
  - The WIDTH+1-bit R prevents overflow when the divisor MSB is set.
  - The invariant dividend = quotient·divisor + remainder, remainder < divisor holds for every nonzero divisor.
- Reset:
  - Any state→IDLE on the next edge; an in-flight division is discarded.
  - quotient=0, remainder=0, div_by_zero=0, out_valid=0, in_ready=1 in the cycle following the reset edge.
  - The counter, Q, R and D are cleared.

## Timing
- Accept edge at cycle k. out_valid is visible from cycle k+WIDTH+1: WIDTH RUN cycles, then DONE. For WIDTH=32, that is 33 cycles after the accept edge.
- Divide by zero: out_valid is visible in cycle k+1.
- in_ready is low from the cycle after accept until the cycle after consumption.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH steps, DONE cycle, then IDLE).
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs except none; in_ready depends only on state.

## Structure
- Shared package (`ycpu_pkg`) holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH constant DIV_WIDTH=32;
  - the counter width function clog2(WIDTH).
- Sub-module `ysub_step`: combinational WIDTH+1-bit subtractor.
  - Built as a chain of 1-bit full adders with b inverted and cin=1.
  - Outputs the difference and the final carry (carry=1 means no borrow).
- Top level holds the FSM, counter and the Q/R/D registers.

## Test plan
- 100 ÷ 7, WIDTH=32, out_ready=1 → quotient=14, remainder=2, div_by_zero=0, out_valid first high 33 cycles after the accept edge, in_ready back high one cycle later.
- 0x12345678 ÷ 0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, out_valid one cycle after accept.
- 0xFFFFFFFF ÷ 0x80000001 → quotient=1, remainder=0x7FFFFFFE (exercises the WIDTH+1 remainder); 0xFFFFFFFF ÷ 1 → quotient=0xFFFFFFFF, remainder=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid and the outputs stay constant, and in_ready stays 0.
  - New in_valid pulses are ignored; then out_ready=1 → IDLE next cycle.
- Reset mid-operation:
  - Assert rst at RUN step 15 of 50 ÷ 3 → next cycle state is IDLE, all outputs zero, in_ready=1.
  - A fresh 9 ÷ 4 then gives quotient=2, remainder=1.
- Randomized back-to-back stream of 1000 operand pairs with random out_ready → every result satisfies q·d+r = dividend, r < d.
